// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory bus arbiter
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INST_BUSY = 3'd1,
        DATA_BUSY = 3'd2,
        INST_DONE = 3'd3,
        DATA_DONE = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [3:0]  SelWord  = 4'b1111;
    localparam int          StarveW  = 4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory bus signals of the arbiter
interface mem_arbiter_if;

    logic        inst_ce_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_data_o;
    logic        inst_stall_o;

    logic        data_ce_i;
    logic        data_we_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_stall_o;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    // Arbiter side
    modport master (
        input  inst_ce_i, inst_addr_i,
        output inst_data_o, inst_stall_o,
        input  data_ce_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
        output data_rdata_o, data_stall_o,
        output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o,
        input  bus_rdata_i, bus_ack_i
    );

    // Pipeline and memory side
    modport slave (
        output inst_ce_i, inst_addr_i,
        input  inst_data_o, inst_stall_o,
        output data_ce_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
        input  data_rdata_o, data_stall_o,
        input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o,
        output bus_rdata_i, bus_ack_i
    );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// rtl/mem_arbiter_watchdog.sv - busy-cycle counter that flags a hung bus transaction
module mem_arbiter_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count runs 0..TIMEOUT-1 across busy cycles; expiry lands on the TIMEOUT-th one
    always_comb begin
        expire_o = 1'b0;
        cnt_d    = '0;
        if (TIMEOUT != 0 && run_i) begin
            if (cnt_q == LAST) begin
                expire_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory bus between instruction fetch and data access
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam logic [StarveW-1:0] STARVE_MAX = StarveW'(STARVE_LIMIT);
    localparam logic [StarveW-1:0] STARVE_SAT = '1;

    arb_state_e         state_q, state_d;
    bus_req_t           req_q, req_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_err_q, bus_err_d;
    logic [31:0]        inst_data_q, inst_data_d;
    logic [31:0]        data_rdata_q, data_rdata_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic               busy, expire;

    assign busy = (state_q == INST_BUSY) || (state_q == DATA_BUSY);

    mem_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_arb_watchdog (
        .clk      (clk),
        .rst      (rst),
        .run_i    (busy),
        .expire_o (expire)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        bus_req_d    = bus_req_q;
        bus_err_d    = 1'b0;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;
        starve_d     = starve_q;

        case (state_q)
            IDLE: begin
                if (!bus.inst_ce_i) begin
                    starve_d = '0;
                end
                // Data wins unless fetch has waited through STARVE_LIMIT data grants
                if (bus.data_ce_i && (starve_q < STARVE_MAX || !bus.inst_ce_i)) begin
                    state_d   = DATA_BUSY;
                    bus_req_d = 1'b1;
                    req_d     = '{we: bus.data_we_i, sel: bus.data_sel_i,
                                  addr: word_align(bus.data_addr_i), wdata: bus.data_wdata_i};
                    if (bus.inst_ce_i && starve_q != STARVE_SAT) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (bus.inst_ce_i) begin
                    state_d   = INST_BUSY;
                    bus_req_d = 1'b1;
                    req_d     = '{we: 1'b0, sel: SelWord,
                                  addr: word_align(bus.inst_addr_i), wdata: ZeroWord};
                    starve_d  = '0;
                end
            end
            INST_BUSY: begin
                if (bus.bus_ack_i) begin
                    state_d     = INST_DONE;
                    bus_req_d   = 1'b0;
                    inst_data_d = bus.bus_rdata_i;
                end else if (expire) begin
                    state_d     = INST_DONE;
                    bus_req_d   = 1'b0;
                    bus_err_d   = 1'b1;
                    inst_data_d = ZeroWord;
                end
            end
            DATA_BUSY: begin
                if (bus.bus_ack_i) begin
                    state_d   = DATA_DONE;
                    bus_req_d = 1'b0;
                    req_d.we  = 1'b0;
                    if (!req_q.we) begin
                        data_rdata_d = bus.bus_rdata_i;
                    end
                end else if (expire) begin
                    state_d      = DATA_DONE;
                    bus_req_d    = 1'b0;
                    req_d.we     = 1'b0;
                    bus_err_d    = 1'b1;
                    data_rdata_d = ZeroWord;
                end
            end
            INST_DONE, DATA_DONE: state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            inst_data_q  <= ZeroWord;
            data_rdata_q <= ZeroWord;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            bus_req_q    <= bus_req_d;
            bus_err_q    <= bus_err_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
            starve_q     <= starve_d;
        end
    end

    assign bus.bus_req_o    = bus_req_q;
    assign bus.bus_we_o     = req_q.we;
    assign bus.bus_sel_o    = req_q.sel;
    assign bus.bus_addr_o   = req_q.addr;
    assign bus.bus_wdata_o  = req_q.wdata;
    assign bus.bus_err_o    = bus_err_q;
    assign bus.inst_data_o  = inst_data_q;
    assign bus.data_rdata_o = data_rdata_q;
    assign bus.inst_stall_o = bus.inst_ce_i & (state_q != INST_DONE);
    assign bus.data_stall_o = bus.data_ce_i & (state_q != DATA_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int STARVE = 4;
    localparam int TMO    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    mem_arbiter_if bif();

    mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.inst_ce_i = 0; bif.inst_addr_i = 0;
        bif.data_ce_i = 0; bif.data_we_i = 0; bif.data_sel_i = 0;
        bif.data_addr_i = 0; bif.data_wdata_i = 0;
        bif.bus_ack_i = 0; bif.bus_rdata_i = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        #3;
        total++; if ({bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_addr_o, bif.bus_wdata_o, bif.bus_err_o} !== '0) $display("FAIL reset_bus: got %h want 0", {bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_addr_o, bif.bus_wdata_o, bif.bus_err_o}); else passed++;
        total++; if (bif.inst_data_o !== 32'h0) $display("FAIL reset_inst_data: got %h want 0", bif.inst_data_o); else passed++;
        total++; if (bif.data_rdata_o !== 32'h0) $display("FAIL reset_data_rdata: got %h want 0", bif.data_rdata_o); else passed++;
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_fetch_only();
        bif.inst_ce_i = 1; bif.inst_addr_i = 32'h0000_0040;
        #1;
        total++; if ({bif.inst_stall_o, bif.bus_req_o} !== 2'b10) $display("FAIL fetch_c0: got %b want 10", {bif.inst_stall_o, bif.bus_req_o}); else passed++;
        tick();
        bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h2401_0005;
        #1;
        total++; if ({bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h40}) $display("FAIL fetch_c1_bus: got %h want %h", {bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_addr_o}, {1'b1, 1'b0, 4'hF, 32'h40}); else passed++;
        tick();
        bif.bus_ack_i = 0;
        #1;
        total++; if ({bif.bus_req_o, bif.inst_stall_o} !== 2'b00) $display("FAIL fetch_c2_done: got %b want 00", {bif.bus_req_o, bif.inst_stall_o}); else passed++;
        total++; if (bif.inst_data_o !== 32'h2401_0005) $display("FAIL fetch_data: got %h want 24010005", bif.inst_data_o); else passed++;
        bif.inst_ce_i = 0;
        tick();
    endtask

    task automatic test_priority();
        bif.inst_ce_i = 1; bif.inst_addr_i = 32'h200;
        bif.data_ce_i = 1; bif.data_we_i = 1; bif.data_sel_i = 4'b0011;
        bif.data_addr_i = 32'h100; bif.data_wdata_i = 32'hDEAD_BEEF;
        tick();
        bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h1234_5678;
        #1;
        total++; if ({bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_addr_o, bif.bus_wdata_o} !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF}) $display("FAIL prio_store_bus: got %h want %h", {bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_addr_o, bif.bus_wdata_o}, {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF}); else passed++;
        tick();
        bif.bus_ack_i = 0;
        #1;
        total++; if ({bif.data_stall_o, bif.inst_stall_o, bif.bus_req_o} !== 3'b010) $display("FAIL prio_store_done: got %b want 010", {bif.data_stall_o, bif.inst_stall_o, bif.bus_req_o}); else passed++;
        bif.data_ce_i = 0; bif.data_we_i = 0;
        tick();
        total++; if ({bif.inst_stall_o, bif.bus_req_o} !== 2'b10) $display("FAIL prio_fetch_wait: got %b want 10", {bif.inst_stall_o, bif.bus_req_o}); else passed++;
        tick();
        bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h8C22_0000;
        #1;
        total++; if ({bif.bus_req_o, bif.bus_we_o, bif.bus_addr_o} !== {1'b1, 1'b0, 32'h200}) $display("FAIL prio_fetch_bus: got %h want %h", {bif.bus_req_o, bif.bus_we_o, bif.bus_addr_o}, {1'b1, 1'b0, 32'h200}); else passed++;
        tick();
        bif.bus_ack_i = 0;
        #1;
        total++; if ({bif.inst_stall_o, bif.inst_data_o} !== {1'b0, 32'h8C22_0000}) $display("FAIL prio_fetch_done: got %h want %h", {bif.inst_stall_o, bif.inst_data_o}, {1'b0, 32'h8C22_0000}); else passed++;
        total++; if (bif.data_rdata_o !== 32'h0) $display("FAIL prio_store_no_rdata: got %h want 0", bif.data_rdata_o); else passed++;
        bif.inst_ce_i = 0;
        tick();
    endtask

    task automatic test_starvation();
        bit g[10];
        int n = 0;
        bif.inst_ce_i = 1; bif.inst_addr_i = 32'h40;
        bif.data_ce_i = 1; bif.data_we_i = 0; bif.data_sel_i = 4'hF; bif.data_addr_i = 32'h100;
        for (int c = 0; c < 200 && n < 10; c++) begin
            tick();
            bif.bus_ack_i = 0;
            if (bif.bus_req_o) begin
                g[n] = (bif.bus_addr_o == 32'h100);
                bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h100 + n;
                n++;
            end
        end
        bif.inst_ce_i = 0; bif.data_ce_i = 0;
        tick();
        bif.bus_ack_i = 0;
        tick();
        total++; if (n !== 10) $display("FAIL starve_grant_count: got %0d want 10", n); else passed++;
        for (int i = 0; i < 10; i++) begin
            total++; if (g[i] !== ((i % (STARVE + 1)) != STARVE)) $display("FAIL starve_seq[%0d]: got data=%0d want data=%0d", i, g[i], (i % (STARVE + 1)) != STARVE); else passed++;
        end
    endtask

    task automatic test_timeout();
        int  busy = 0, errs = 0;
        bit  ended = 0;
        bif.data_ce_i = 1; bif.data_we_i = 0; bif.data_sel_i = 4'hF; bif.data_addr_i = 32'h80;
        for (int c = 0; c < 60 && !ended; c++) begin
            tick();
            if (bif.bus_err_o) errs++;
            if (bif.bus_req_o) busy++;
            else if (busy > 0) ended = 1;
        end
        total++; if ({ended, 8'(busy)} !== {1'b1, 8'(TMO)}) $display("FAIL timeout_busy_cycles: got ended=%0d busy=%0d want ended=1 busy=%0d", ended, busy, TMO); else passed++;
        total++; if ({bif.bus_err_o, bif.data_stall_o} !== 2'b10) $display("FAIL timeout_err_stall: got %b want 10", {bif.bus_err_o, bif.data_stall_o}); else passed++;
        total++; if (bif.data_rdata_o !== 32'h0) $display("FAIL timeout_rdata: got %h want 0", bif.data_rdata_o); else passed++;
        bif.data_ce_i = 0;
        tick();
        if (bif.bus_err_o) errs++;
        total++; if (errs !== 1) $display("FAIL timeout_err_pulses: got %0d want 1", errs); else passed++;
    endtask

    task automatic test_ack_at_limit();
        int  busy = 0;
        bit  ended = 0;
        bif.data_ce_i = 1; bif.data_we_i = 0; bif.data_addr_i = 32'h84;
        for (int c = 0; c < 60 && !ended; c++) begin
            tick();
            bif.bus_ack_i = 0;
            #1;
            if (bif.bus_req_o) begin
                busy++;
                if (busy == TMO) begin bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h5A5A_1234; end
            end else if (busy > 0) ended = 1;
        end
        total++; if ({ended, bif.bus_err_o, bif.data_stall_o} !== 3'b100) $display("FAIL ack_at_limit_err: got %b want 100", {ended, bif.bus_err_o, bif.data_stall_o}); else passed++;
        total++; if (bif.data_rdata_o !== 32'h5A5A_1234) $display("FAIL ack_at_limit_rdata: got %h want 5a5a1234", bif.data_rdata_o); else passed++;
        bif.data_ce_i = 0;
        tick();
    endtask

    task automatic test_async_reset();
        bif.data_ce_i = 1; bif.data_we_i = 1; bif.data_sel_i = 4'hF;
        bif.data_addr_i = 32'hC0; bif.data_wdata_i = 32'h1111_2222;
        tick();
        #1;
        total++; if ({bif.bus_req_o, bif.bus_we_o} !== 2'b11) $display("FAIL areset_pre_busy: got %b want 11", {bif.bus_req_o, bif.bus_we_o}); else passed++;
        #2;
        bif.data_ce_i = 0;
        rst = 0;
        #1;
        total++; if ({bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_addr_o, bif.bus_wdata_o, bif.bus_err_o, bif.inst_data_o, bif.data_rdata_o, bif.inst_stall_o, bif.data_stall_o} !== '0) $display("FAIL areset_outputs: got %h want 0", {bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_addr_o, bif.bus_wdata_o, bif.bus_err_o, bif.inst_data_o, bif.data_rdata_o, bif.inst_stall_o, bif.data_stall_o}); else passed++;
        tick();
        rst = 1;
        bif.inst_ce_i = 1; bif.inst_addr_i = 32'h48;
        tick();
        bif.bus_ack_i = 1; bif.bus_rdata_i = 32'hABCD_0001;
        total++; if ({bif.bus_req_o, bif.bus_addr_o} !== {1'b1, 32'h48}) $display("FAIL areset_restart_bus: got %h want %h", {bif.bus_req_o, bif.bus_addr_o}, {1'b1, 32'h48}); else passed++;
        tick();
        bif.bus_ack_i = 0;
        #1;
        total++; if ({bif.inst_stall_o, bif.inst_data_o} !== {1'b0, 32'hABCD_0001}) $display("FAIL areset_restart_done: got %h want %h", {bif.inst_stall_o, bif.inst_data_o}, {1'b0, 32'hABCD_0001}); else passed++;
        bif.inst_ce_i = 0;
        tick();
    endtask

    task automatic test_wait_drop();
        bif.data_ce_i = 1; bif.data_we_i = 0; bif.data_sel_i = 4'hF; bif.data_addr_i = 32'h44;
        tick();
        tick();
        bif.data_ce_i = 0;
        #1;
        total++; if ({bif.bus_req_o, bif.data_stall_o} !== 2'b10) $display("FAIL drop_no_abort: got %b want 10", {bif.bus_req_o, bif.data_stall_o}); else passed++;
        tick();
        tick();
        bif.bus_ack_i = 1; bif.bus_rdata_i = 32'hCAFE_F00D;
        tick();
        bif.bus_ack_i = 0;
        #1;
        total++; if ({bif.bus_req_o, bif.data_stall_o, bif.data_rdata_o} !== {2'b00, 32'hCAFE_F00D}) $display("FAIL drop_complete: got %h want %h", {bif.bus_req_o, bif.data_stall_o, bif.data_rdata_o}, {2'b00, 32'hCAFE_F00D}); else passed++;
        tick();
        bif.data_ce_i = 1; bif.data_addr_i = 32'h48;
        tick();
        bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h0000_0077;
        total++; if ({bif.bus_req_o, bif.bus_addr_o} !== {1'b1, 32'h48}) $display("FAIL drop_next_bus: got %h want %h", {bif.bus_req_o, bif.bus_addr_o}, {1'b1, 32'h48}); else passed++;
        tick();
        bif.bus_ack_i = 0;
        #1;
        total++; if ({bif.data_stall_o, bif.data_rdata_o} !== {1'b0, 32'h77}) $display("FAIL drop_next_done: got %h want %h", {bif.data_stall_o, bif.data_rdata_o}, {1'b0, 32'h77}); else passed++;
        bif.data_ce_i = 0;
        tick();
    endtask

    task automatic test_idle_ack();
        bif.bus_ack_i = 1; bif.bus_rdata_i = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if ({bif.bus_req_o, bif.data_rdata_o} !== {1'b0, 32'h77}) $display("FAIL idle_ack_ignored[%0d]: got %h want %h", c, {bif.bus_req_o, bif.data_rdata_o}, {1'b0, 32'h77}); else passed++;
        end
        bif.bus_ack_i = 0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] ref_mem[16];
        logic [31:0] resp_mem[16];
        logic [31:0] i_a = 0, d_a = 0, d_wd = 0;
        logic [3:0]  d_sel = 0;
        logic        d_we = 0;
        bit i_busy = 0, i_done = 0, d_busy = 0, d_done = 0, rsp_active = 0;
        int rsp_wait = 0, run = 0, n_inst = 0, n_load = 0;
        for (int k = 0; k < 16; k++) begin ref_mem[k] = $urandom; resp_mem[k] = ref_mem[k]; end
        for (int c = 0; c < 800; c++) begin
            tick();
            bif.bus_ack_i = 0;
            if (bif.bus_req_o) begin
                if (!rsp_active) begin
                    rsp_active = 1;
                    rsp_wait = $urandom_range(0, 3);
                    total++; if (bif.bus_addr_o[1:0] !== 2'b00) $display("FAIL rand_addr_align: got %h", bif.bus_addr_o); else passed++;
                    if (bif.bus_addr_o >= 32'h1000) run = 0;
                    else if (i_busy) run++;
                    else run = 0;
                    total++; if (run > STARVE) $display("FAIL rand_starve: got %0d consecutive data grants want <= %0d", run, STARVE); else passed++;
                end
                if (rsp_wait == 0) begin
                    bif.bus_ack_i = 1;
                    rsp_active = 0;
                    if (bif.bus_addr_o >= 32'h1000) bif.bus_rdata_i = inst_word(bif.bus_addr_o);
                    else begin
                        bif.bus_rdata_i = resp_mem[bif.bus_addr_o[5:2]];
                        if (bif.bus_we_o) resp_mem[bif.bus_addr_o[5:2]] = merge(resp_mem[bif.bus_addr_o[5:2]], bif.bus_wdata_o, bif.bus_sel_o);
                    end
                end else rsp_wait--;
            end
            if (i_done) begin i_busy = 0; i_done = 0; bif.inst_ce_i = 0; end
            if (!i_busy && $urandom_range(0, 2) == 0) begin
                i_busy = 1;
                i_a = 32'h1000 + ($urandom_range(0, 63) << 2);
                bif.inst_ce_i = 1; bif.inst_addr_i = i_a;
            end
            if (d_done) begin d_busy = 0; d_done = 0; bif.data_ce_i = 0; end
            if (!d_busy && $urandom_range(0, 1) == 0) begin
                d_busy = 1;
                d_a   = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                d_we  = 1'($urandom_range(0, 1));
                d_sel = d_we ? 4'($urandom_range(1, 15)) : 4'hF;
                d_wd  = $urandom;
                bif.data_ce_i = 1; bif.data_we_i = d_we; bif.data_sel_i = d_sel;
                bif.data_addr_i = d_a; bif.data_wdata_i = d_wd;
            end
            #1;
            if (bif.inst_ce_i && !bif.inst_stall_o) begin
                total++; if (bif.inst_data_o !== inst_word({i_a[31:2], 2'b00})) $display("FAIL rand_fetch: addr %h got %h want %h", i_a, bif.inst_data_o, inst_word({i_a[31:2], 2'b00})); else passed++;
                i_done = 1; n_inst++;
            end
            if (bif.data_ce_i && !bif.data_stall_o) begin
                if (d_we) ref_mem[d_a[5:2]] = merge(ref_mem[d_a[5:2]], d_wd, d_sel);
                else begin
                    total++; if (bif.data_rdata_o !== ref_mem[d_a[5:2]]) $display("FAIL rand_load: addr %h got %h want %h", d_a, bif.data_rdata_o, ref_mem[d_a[5:2]]); else passed++;
                    n_load++;
                end
                d_done = 1;
            end
            total++; if (bif.bus_err_o !== 1'b0) $display("FAIL rand_no_err: got %b want 0", bif.bus_err_o); else passed++;
        end
        bif.inst_ce_i = 0; bif.data_ce_i = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            bif.bus_ack_i = bif.bus_req_o;
        end
        bif.bus_ack_i = 0;
        tick();
        total++; if (n_inst < 10 || n_load < 10) $display("FAIL rand_activity: got fetches=%0d loads=%0d want >= 10 each", n_inst, n_load); else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_priority();
        test_starvation();
        test_timeout();
        test_ack_at_limit();
        test_async_reset();
        test_wait_drop();
        test_idle_ack();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
